// File: rtl/simple_st0_data_tx.sv
// Stage_0_data transmitter: streams frames out of a sync-read sample RAM as vld/rdy/fst beats.
// An output register plus a small skid buffer hides the one-cycle RAM latency for full-rate streaming.
module simple_st0_data_tx #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int LEN_W  = 6,
  parameter int CNT_W  = 8,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_length,
  input  logic [CNT_W-1:0]  frame_count,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] stage_data,
  output logic              stage_data_fst,
  output logic              stage_data_vld,
  input  logic              stage_data_rdy,
  output logic              busy,
  output logic              done
);

  localparam int TOT_W = LEN_W + CNT_W;
  // The output register is one of the FIFO_D slots; the buffer holds the rest.
  localparam int BUF_D = FIFO_D - 1;
  localparam int PTR_W = (BUF_D > 1) ? $clog2(BUF_D) : 1;
  localparam int OCC_W = $clog2(FIFO_D + 3) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   elem_r;
  logic [ADDR_W-1:0]  base_r;
  logic [TOT_W-1:0]   total_r;
  logic [TOT_W-1:0]   issue_cnt_r;
  logic               mem_rd_en_r;
  logic [ADDR_W-1:0]  mem_rd_addr_r;
  logic               rd_fst_r;
  logic               pend_vld_r;
  logic               pend_fst_r;
  logic [DATA_W-1:0]  buf_data_r [BUF_D];
  logic               buf_fst_r  [BUF_D];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [OCC_W-1:0]   buf_cnt_r;
  logic [DATA_W-1:0]  out_data_r;
  logic               out_fst_r;
  logic               out_vld_r;
  logic               busy_r;
  logic               done_r;

  logic               pop_s;
  logic               load_out_s;
  logic               buf_empty_s;
  logic               buf_pop_s;
  logic               bypass_s;
  logic               buf_push_s;
  logic [OCC_W-1:0]   outstanding_s;
  logic               credit_s;
  logic               drain_end_s;
  logic [TOT_W-1:0]   total_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(BUF_D - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  // Handshake, buffer steering and read-credit decisions.
  always_comb begin
    pop_s       = out_vld_r & stage_data_rdy;
    load_out_s  = ~out_vld_r | pop_s;
    buf_empty_s = (buf_cnt_r == OCC_W'(0));
    buf_pop_s   = load_out_s & ~buf_empty_s;
    bypass_s    = load_out_s & buf_empty_s & pend_vld_r;
    buf_push_s  = pend_vld_r & ~bypass_s;
    // Occupancy next cycle, counting this cycle's read and the one whose data is on the bus.
    outstanding_s = OCC_W'(out_vld_r) + buf_cnt_r + OCC_W'(pend_vld_r)
                  + OCC_W'(mem_rd_en_r) - OCC_W'(pop_s);
    credit_s    = (outstanding_s < OCC_W'(FIFO_D));
    drain_end_s = pop_s & buf_empty_s & ~pend_vld_r & ~mem_rd_en_r;
    total_s     = TOT_W'(frame_length) * TOT_W'(frame_count);
  end

  // Control FSM and RAM read issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      len_r         <= LEN_W'(0);
      elem_r        <= LEN_W'(0);
      base_r        <= ADDR_W'(0);
      total_r       <= TOT_W'(0);
      issue_cnt_r   <= TOT_W'(0);
      mem_rd_en_r   <= 1'b0;
      mem_rd_addr_r <= ADDR_W'(0);
      rd_fst_r      <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      mem_rd_en_r <= 1'b0;
      done_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if ((frame_length != LEN_W'(0)) && (frame_count != CNT_W'(0))) begin
              len_r         <= frame_length;
              base_r        <= base_addr;
              total_r       <= total_s;
              mem_rd_en_r   <= 1'b1;
              mem_rd_addr_r <= base_addr;
              rd_fst_r      <= 1'b1;
              issue_cnt_r   <= TOT_W'(1);
              elem_r        <= (frame_length == LEN_W'(1)) ? LEN_W'(0) : LEN_W'(1);
              busy_r        <= 1'b1;
              state_r       <= (total_s == TOT_W'(1)) ? DRAIN : RUN;
            end else begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end
          end
        end
        RUN: begin
          if (credit_s) begin
            mem_rd_en_r   <= 1'b1;
            mem_rd_addr_r <= base_r + issue_cnt_r[ADDR_W-1:0];
            rd_fst_r      <= (elem_r == LEN_W'(0));
            elem_r        <= (elem_r == len_r - LEN_W'(1)) ? LEN_W'(0) : elem_r + LEN_W'(1);
            issue_cnt_r   <= issue_cnt_r + TOT_W'(1);
            if (issue_cnt_r + TOT_W'(1) == total_r) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_end_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Read-data capture, skid buffer and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld_r <= 1'b0;
      pend_fst_r <= 1'b0;
      for (int i = 0; i < BUF_D; i++) begin
        buf_data_r[i] <= {DATA_W{1'b0}};
        buf_fst_r[i]  <= 1'b0;
      end
      wr_ptr_r   <= PTR_W'(0);
      rd_ptr_r   <= PTR_W'(0);
      buf_cnt_r  <= OCC_W'(0);
      out_data_r <= {DATA_W{1'b0}};
      out_fst_r  <= 1'b0;
      out_vld_r  <= 1'b0;
    end else begin
      pend_vld_r <= mem_rd_en_r;
      pend_fst_r <= rd_fst_r;
      if (load_out_s) begin
        if (buf_pop_s) begin
          out_data_r <= buf_data_r[rd_ptr_r];
          out_fst_r  <= buf_fst_r[rd_ptr_r];
          out_vld_r  <= 1'b1;
          rd_ptr_r   <= ptr_inc(rd_ptr_r);
        end else if (bypass_s) begin
          out_data_r <= mem_rd_data;
          out_fst_r  <= pend_fst_r;
          out_vld_r  <= 1'b1;
        end else begin
          out_vld_r  <= 1'b0;
        end
      end
      if (buf_push_s) begin
        buf_data_r[wr_ptr_r] <= mem_rd_data;
        buf_fst_r[wr_ptr_r]  <= pend_fst_r;
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end
      case ({buf_push_s, buf_pop_s})
        2'b10:   buf_cnt_r <= buf_cnt_r + OCC_W'(1);
        2'b01:   buf_cnt_r <= buf_cnt_r - OCC_W'(1);
        default: buf_cnt_r <= buf_cnt_r;
      endcase
    end
  end

  assign mem_rd_en      = mem_rd_en_r;
  assign mem_rd_addr    = mem_rd_addr_r;
  assign stage_data     = out_data_r;
  assign stage_data_fst = out_fst_r;
  assign stage_data_vld = out_vld_r;
  assign busy           = busy_r;
  assign done           = done_r;

endmodule
